// File: rtl/inta_sequencer_if.sv
// Handshake/bus bundle between the 8259-style INTA sequencer and its surroundings.
// Latency: none (wires only).
// Backpressure: none; the CPU paces the sequence through INTA_n.
// Ports:
//   master drives pendingIRR, INTA_n, vectorBase, autoEOI and eoiStrobe.
//   slave (the sequencer) drives INT, readPriority, resetIRR, dataBus, dataBusEn and ISR.
interface inta_sequencer_if;
    logic [7:0] pendingIRR;
    logic       INTA_n;
    logic [4:0] vectorBase;
    logic       autoEOI;
    logic       eoiStrobe;
    logic       INT;
    logic       readPriority;
    logic [2:0] resetIRR;
    logic [7:0] dataBus;
    logic       dataBusEn;
    logic [7:0] ISR;

    modport master (
        output pendingIRR, INTA_n, vectorBase, autoEOI, eoiStrobe,
        input  INT, readPriority, resetIRR, dataBus, dataBusEn, ISR
    );

    modport slave (
        input  pendingIRR, INTA_n, vectorBase, autoEOI, eoiStrobe,
        output INT, readPriority, resetIRR, dataBus, dataBusEn, ISR
    );
endinterface

// File: rtl/inta_sequencer.sv
// Interrupt acknowledge sequencer: resolves priority, raises INT, runs the two-pulse INTA cycle and keeps the ISR.
// Latency: all outputs registered; INT rises one cycle after a grant, the vector is driven one cycle after the second INTA falling edge.
// Backpressure: none; the CPU paces the handshake via INTA_n, and each step waits for the next INTA edge.
// Ports: clk, reset (synchronous, active high); bus (slave modport of inta_sequencer_if).
// Build option: define ROTATE_ON_EOI_EN for rotate-on-EOI priority; otherwise IR0 is fixed highest priority.
module inta_sequencer (
    input  logic            clk,
    input  logic            reset,
    inta_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ACK1 = 3'd2,
        GAP  = 3'd3,
        ACK2 = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       inta_prev_q, inta_prev_d;
    logic [2:0] index_q, index_d;
    logic       spurious_q, spurious_d;
    logic [7:0] isr_q, isr_d;
    logic       int_q, int_d;
    logic       read_priority_q, read_priority_d;
    logic [2:0] reset_irr_q, reset_irr_d;
    logic [7:0] data_bus_q, data_bus_d;
    logic       data_bus_en_q, data_bus_en_d;

    // Level currently holding highest priority.
    logic [2:0] prio_ptr;
`ifdef ROTATE_ON_EOI_EN
    logic [2:0] rot_ptr_q, rot_ptr_d;
    assign prio_ptr = rot_ptr_q;
`else
    assign prio_ptr = 3'd0;
`endif

    // Returns {found, rank}: rank is the distance from ptr of the
    // highest-priority set bit, so a smaller rank means higher priority.
    function automatic logic [3:0] first_set(input logic [7:0] vec, input logic [2:0] ptr);
        logic [7:0] rot;
        logic [3:0] res;
        rot = (vec >> ptr) | (vec << (4'd8 - {1'b0, ptr}));
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot[k]) res = {1'b1, 3'(k)};
        end
        return res;
    endfunction

    logic [3:0] pend_first, isr_first;
    logic       grant;
    logic [2:0] win_idx, isr_top_idx;
    logic       inta_fall, inta_rise;

    always_comb begin
        pend_first  = first_set(bus.pendingIRR, prio_ptr);
        isr_first   = first_set(isr_q, prio_ptr);
        // Fully nested: only a level strictly above every in-service level wins.
        grant       = pend_first[3] && (!isr_first[3] || (pend_first[2:0] < isr_first[2:0]));
        win_idx     = pend_first[2:0] + prio_ptr;
        isr_top_idx = isr_first[2:0] + prio_ptr;
        inta_fall   = !bus.INTA_n && inta_prev_q;
        inta_rise   = bus.INTA_n && !inta_prev_q;

        state_d         = state_q;
        index_d         = index_q;
        spurious_d      = spurious_q;
        read_priority_d = 1'b0;
        reset_irr_d     = reset_irr_q;
        inta_prev_d     = bus.INTA_n;
        isr_d           = isr_q;
`ifdef ROTATE_ON_EOI_EN
        rot_ptr_d       = rot_ptr_q;
`endif

        // Non-specific EOI works on the ISR as it stood before this cycle's set.
        if (bus.eoiStrobe && isr_first[3]) begin
            isr_d[isr_top_idx] = 1'b0;
`ifdef ROTATE_ON_EOI_EN
            rot_ptr_d = isr_top_idx + 3'd1;
`endif
        end

        case (state_q)
            IDLE: if (grant) state_d = REQ;
            REQ: begin
                if (inta_fall) begin
                    state_d = ACK1;
                    if (grant) begin
                        index_d         = win_idx;
                        spurious_d      = 1'b0;
                        read_priority_d = 1'b1;
                        reset_irr_d     = win_idx;
                    end else begin
                        // Request withdrawn before acknowledge: answer with IR7.
                        index_d    = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
            end
            ACK1: if (inta_rise) state_d = GAP;
            GAP:  if (inta_fall) state_d = ACK2;
            ACK2: begin
                if (inta_rise) begin
                    state_d = IDLE;
                    // A spurious IR7 was never put in service, so nothing to end.
                    if (bus.autoEOI && !spurious_q) begin
                        isr_d[index_q] = 1'b0;
`ifdef ROTATE_ON_EOI_EN
                        rot_ptr_d = index_q + 3'd1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // ISR bit lands the cycle after the readPriority pulse.
        if (read_priority_q) isr_d[reset_irr_q] = 1'b1;

        int_d         = (state_d == REQ) || (state_d == ACK1) || (state_d == GAP);
        data_bus_en_d = (state_d == ACK2);
        data_bus_d    = data_bus_en_d ? {bus.vectorBase, index_d} : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            inta_prev_q     <= 1'b1;
            index_q         <= 3'd0;
            spurious_q      <= 1'b0;
            isr_q           <= 8'h00;
            int_q           <= 1'b0;
            read_priority_q <= 1'b0;
            reset_irr_q     <= 3'd0;
            data_bus_q      <= 8'h00;
            data_bus_en_q   <= 1'b0;
`ifdef ROTATE_ON_EOI_EN
            rot_ptr_q       <= 3'd0;
`endif
        end else begin
            state_q         <= state_d;
            inta_prev_q     <= inta_prev_d;
            index_q         <= index_d;
            spurious_q      <= spurious_d;
            isr_q           <= isr_d;
            int_q           <= int_d;
            read_priority_q <= read_priority_d;
            reset_irr_q     <= reset_irr_d;
            data_bus_q      <= data_bus_d;
            data_bus_en_q   <= data_bus_en_d;
`ifdef ROTATE_ON_EOI_EN
            rot_ptr_q       <= rot_ptr_d;
`endif
        end
    end

    assign bus.INT          = int_q;
    assign bus.readPriority = read_priority_q;
    assign bus.resetIRR     = reset_irr_q;
    assign bus.dataBus      = data_bus_q;
    assign bus.dataBusEn    = data_bus_en_q;
    assign bus.ISR          = isr_q;
endmodule
